// File: rtl/fillscreen_engine.sv
// Full-frame sweep: emits every (x,y) of the framebuffer once, column-major,
// with colour taken from the low bits of the column index.
module fillscreen_engine #(
  parameter int unsigned WIDTH  = 160,
  parameter int unsigned HEIGHT = 120,
  parameter int unsigned X_BITS = 8,
  parameter int unsigned Y_BITS = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              done,
  output logic [X_BITS-1:0] vga_x,
  output logic [Y_BITS-1:0] vga_y,
  output logic [2:0]        vga_colour,
  output logic              vga_plot
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } state_t;

  localparam logic [X_BITS-1:0] X_LAST = X_BITS'(WIDTH - 1);
  localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(HEIGHT - 1);

  state_t            state_q, state_d;
  logic [X_BITS-1:0] x_q, x_d;
  logic [Y_BITS-1:0] y_q, y_d;
  logic              plot_q, plot_d;
  logic              done_q, done_d;

  logic last_x;
  logic last_y;

  assign last_x = (x_q == X_LAST);
  assign last_y = (y_q == Y_LAST);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FILL;
          x_d     = '0;
          y_d     = '0;
        end
      end
      FILL: begin
        // start is deliberately ignored: a frame always completes
        if (last_y) begin
          y_d = '0;
          if (last_x) begin
            state_d = DONE;
            x_d     = '0;
          end else begin
            x_d = x_q + X_BITS'(1);
          end
        end else begin
          y_d = y_q + Y_BITS'(1);
        end
      end
      DONE: begin
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    plot_d = (state_d == FILL);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      plot_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      plot_q  <= plot_d;
      done_q  <= done_d;
    end
  end

  assign done       = done_q;
  assign vga_plot   = plot_q;
  assign vga_x      = x_q;
  assign vga_y      = y_q;
  assign vga_colour = x_q[2:0];

endmodule

// File: tb/tb_fillscreen_engine.sv
// Bench for fillscreen_engine: pixel-index reference model,
// per-cycle stream comparison and frame-level checks.
module tb_fillscreen_engine;

  localparam int W = 160;
  localparam int H = 120;
  localparam int N = W * H;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       done;
  logic       vga_plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;

  fillscreen_engine #(
    .WIDTH(W),
    .HEIGHT(H),
    .X_BITS(8),
    .Y_BITS(7)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .done(done),
    .vga_x(vga_x),
    .vga_y(vga_y),
    .vga_colour(vga_colour),
    .vga_plot(vga_plot)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: 0 idle, 1 sweeping pixel index m_p, 2 finished
  int m_st = 0;
  int m_p  = 0;

  int j, n_strobe, done_cnt, done_first, outside;
  int fx, fy, fc, sx, sy, sc, lx, ly, lc;
  int cov[W][H];
  int bad, bad_cyc;
  logic [19:0] bad_act, bad_exp;

  function automatic logic [19:0] out_vec();
    return {done, vga_plot, vga_x, vga_y, vga_colour};
  endfunction

  function automatic logic [19:0] exp_vec();
    logic [7:0] ex;
    logic [6:0] ey;
    ex = (m_st == 1) ? 8'(m_p / H) : 8'd0;
    ey = (m_st == 1) ? 7'(m_p % H) : 7'd0;
    return {(m_st == 2), (m_st == 1), ex, ey, ex[2:0]};
  endfunction

  task automatic clear_stats();
    j = 0;
    n_strobe = 0;
    done_cnt = 0;
    done_first = -1;
    outside = 0;
    bad = 0;
    bad_cyc = -1;
    bad_act = '0;
    bad_exp = '0;
    for (int a = 0; a < W; a++)
      for (int b = 0; b < H; b++)
        cov[a][b] = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m_st = 0;
    end else if (m_st == 0) begin
      if (start) begin
        m_st = 1;
        m_p  = 0;
      end
    end else if (m_st == 1) begin
      if (m_p == N - 1) m_st = 2;
      else m_p++;
    end else if (!start) begin
      m_st = 0;
    end
    @(negedge clk);
    j++;
    if (vga_plot) begin
      n_strobe++;
      if (n_strobe == 1) begin
        fx = vga_x; fy = vga_y; fc = vga_colour;
      end
      if (n_strobe == 121) begin
        sx = vga_x; sy = vga_y; sc = vga_colour;
      end
      lx = vga_x; ly = vga_y; lc = vga_colour;
      if (vga_x < W && vga_y < H) cov[vga_x][vga_y]++;
      else outside++;
    end
    if (done) begin
      done_cnt++;
      if (done_first < 0) done_first = j;
    end
  endtask

  task automatic test_reset();
    start = 1'b0;
    #2 rst_n = 1'b0;
    m_st = 0;
    #1;
    checks++;
    if (out_vec() !== 20'd0) begin
      errors++;
      $display("FAIL reset_state got %0h want 0", out_vec());
    end
    clear_stats();
    repeat (3) begin
      tick();
      if (out_vec() !== 20'd0) begin
        if (bad == 0) begin bad_cyc = j; bad_act = out_vec(); end
        bad++;
      end
    end
    rst_n = 1'b1;
    repeat (100) begin
      tick();
      if (out_vec() !== 20'd0) begin
        if (bad == 0) begin bad_cyc = j; bad_act = out_vec(); end
        bad++;
      end
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL reset_idle cyc %0d got %0h want 0", bad_cyc, bad_act);
    end
  endtask

  task automatic test_single_frame();
    int cov_bad;
    clear_stats();
    start = 1'b1;
    repeat (19210) begin
      tick();
      if (out_vec() !== exp_vec()) begin
        if (bad == 0) begin
          bad_cyc = j; bad_act = out_vec(); bad_exp = exp_vec();
        end
        bad++;
      end
    end
    checks++;
    if (n_strobe !== N) begin
      errors++;
      $display("FAIL frame_strobes got %0d want %0d", n_strobe, N);
    end
    checks++;
    if (fx !== 0 || fy !== 0 || fc !== 0) begin
      errors++;
      $display("FAIL first_strobe got (%0d,%0d,%0d) want (0,0,0)", fx, fy, fc);
    end
    checks++;
    if (sx !== 1 || sy !== 0 || sc !== 1) begin
      errors++;
      $display("FAIL strobe_121 got (%0d,%0d,%0d) want (1,0,1)", sx, sy, sc);
    end
    checks++;
    if (lx !== 159 || ly !== 119 || lc !== 7) begin
      errors++;
      $display("FAIL last_strobe got (%0d,%0d,%0d) want (159,119,7)", lx, ly, lc);
    end
    checks++;
    if (done_first !== 19201) begin
      errors++;
      $display("FAIL done_rise got %0d want 19201", done_first);
    end
    checks++;
    if (done_cnt !== 10 || done !== 1'b1) begin
      errors++;
      $display("FAIL done_hold got %0d cycles want 10", done_cnt);
    end
    cov_bad = 0;
    for (int a = 0; a < W; a++)
      for (int b = 0; b < H; b++)
        if (cov[a][b] != 1) cov_bad++;
    checks++;
    if (cov_bad !== 0 || outside !== 0) begin
      errors++;
      $display("FAIL coverage got %0d bad cells %0d outside want 0 0", cov_bad, outside);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL frame_stream cyc %0d got %0h want %0h", bad_cyc, bad_act, bad_exp);
    end
    start = 1'b0;
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_fall got %0b want 0", done);
    end
  endtask

  task automatic test_repeated();
    for (int it = 2; it <= 3; it++) begin
      clear_stats();
      start = 1'b1;
      repeat (19210) begin
        tick();
        if (out_vec() !== exp_vec()) begin
          if (bad == 0) begin
            bad_cyc = j; bad_act = out_vec(); bad_exp = exp_vec();
          end
          bad++;
        end
      end
      start = 1'b0;
      tick();
      checks++;
      if (n_strobe !== N || bad !== 0) begin
        errors++;
        $display("FAIL repeat_frame%0d strobes %0d mism %0d at %0d got %0h want %0h",
                 it, n_strobe, bad, bad_cyc, bad_act, bad_exp);
      end
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL repeat_done_fall%0d got %0b want 0", it, done);
      end
    end
  endtask

  task automatic test_mid_reset_early_drop();
    int off, drop, rbad;
    clear_stats();
    start = 1'b1;
    off = int'($urandom_range(0, 20));
    repeat (5000 + off) tick();
    #2 rst_n = 1'b0;
    #1;
    m_st = 0;
    checks++;
    if (vga_plot !== 1'b0 || out_vec() !== 20'd0) begin
      errors++;
      $display("FAIL async_reset got %0h want 0", out_vec());
    end
    rbad = 0;
    repeat (2) begin
      tick();
      if (out_vec() !== 20'd0) rbad++;
    end
    checks++;
    if (rbad !== 0) begin
      errors++;
      $display("FAIL reset_hold got %0d bad cycles want 0", rbad);
    end
    rst_n = 1'b1;
    clear_stats();
    tick();
    checks++;
    if (vga_plot !== 1'b1 || vga_x !== 8'd0 || vga_y !== 7'd0) begin
      errors++;
      $display("FAIL restart got plot %0b (%0d,%0d) want 1 (0,0)", vga_plot, vga_x, vga_y);
    end
    drop = int'($urandom_range(40, 60));
    while (j < 19205) begin
      if (j < drop) start = 1'b1;
      else if (j < 19000) start = 1'($urandom_range(0, 1));
      else start = 1'b0;
      tick();
      if (out_vec() !== exp_vec()) begin
        if (bad == 0) begin
          bad_cyc = j; bad_act = out_vec(); bad_exp = exp_vec();
        end
        bad++;
      end
    end
    checks++;
    if (n_strobe !== N) begin
      errors++;
      $display("FAIL drop_strobes got %0d want %0d", n_strobe, N);
    end
    checks++;
    if (done_first !== 19201 || done_cnt !== 1) begin
      errors++;
      $display("FAIL drop_done got first %0d count %0d want 19201 1", done_first, done_cnt);
    end
    checks++;
    if (out_vec() !== 20'd0) begin
      errors++;
      $display("FAIL drop_idle got %0h want 0", out_vec());
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL drop_stream cyc %0d got %0h want %0h", bad_cyc, bad_act, bad_exp);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_repeated();
    test_mid_reset_early_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
